// File: rtl/bpi_pkg.sv
// Shared types, default timing and helpers for the BPI parallel-flash controller.
package bpi_pkg;

    typedef enum logic [1:0] {
        OpStandby    = 2'b00,
        OpWrite      = 2'b01,
        OpRead       = 2'b10,
        OpStandbyAlt = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StWrite,
        StRdWait,
        StSample,
        StTurn
    } state_e;

    localparam int unsigned TLatchDef = 2;
    localparam int unsigned TWrDef    = 4;
    localparam int unsigned TRdDef    = 6;
    localparam int unsigned TTurnDef  = 1;
    localparam int unsigned TPageDef  = 2;

    // A phase lasting N cycles loads the down-counter with N-1 so that it
    // expires on the phase's final cycle.
    function automatic logic [7:0] tmr_init(input int unsigned cycles);
        return 8'(cycles - 1);
    endfunction

    function automatic logic is_access(input op_e op);
        return (op == OpWrite) || (op == OpRead);
    endfunction

endpackage

// File: rtl/bpi_ctrl_param_if.sv
// Command-side handshake between the programming sequencer and the BPI controller.
interface bpi_ctrl_param_if #(
    parameter int unsigned AW  = 23,
    parameter int unsigned DW  = 16,
    parameter int unsigned BLW = 5
) ();

    logic [AW-1:0]  ADDR;
    logic [DW-1:0]  CMD_DATA_OUT;
    logic [1:0]     OP;
    logic [BLW-1:0] BURST_LEN;
    logic           EXECUTE;
    logic           BUSY;
    logic           DONE;
    logic [DW-1:0]  DATA_IN;
    logic           LOAD_DATA;

    modport master (
        output ADDR, CMD_DATA_OUT, OP, BURST_LEN, EXECUTE,
        input  BUSY, DONE, DATA_IN, LOAD_DATA
    );

    modport slave (
        input  ADDR, CMD_DATA_OUT, OP, BURST_LEN, EXECUTE,
        output BUSY, DONE, DATA_IN, LOAD_DATA
    );

endinterface

// File: rtl/bpi_phase_timer.sv
// 8-bit loadable down-counter shared by all timed bus phases; expire_o flags zero.
module bpi_phase_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       expire_o
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == 8'd0);

endmodule

// File: rtl/bpi_ctrl_param.sv
// Parametrised BPI flash bus controller with programmable phase timing and burst reads.
// Define BPI_PAGE_MODE_EN to skip relatching for in-page burst words.
module bpi_ctrl_param
    import bpi_pkg::*;
#(
    parameter int unsigned AW      = 23,
    parameter int unsigned DW      = 16,
    parameter int unsigned BLW     = 5,
    parameter int unsigned T_LATCH = TLatchDef,
    parameter int unsigned T_WR    = TWrDef,
    parameter int unsigned T_RD    = TRdDef,
    parameter int unsigned T_TURN  = TTurnDef,
    parameter int unsigned T_PAGE  = TPageDef
) (
    input  logic                   CLK,
    input  logic                   RST,
    bpi_ctrl_param_if.slave        bus,
    input  logic                   BPI_ACTIVE,
    input  logic [DW-1:0]          DUAL_DATA,
    output logic [AW-1:0]          BPI_AD_O,
    input  logic [DW-1:0]          CFG_DAT_I,
    output logic [DW-1:0]          CFG_DAT_O,
    output logic [DW-1:0]          CFG_DAT_T,
    output logic                   FCS_B,
    output logic                   FOE_B,
    output logic                   FWE_B,
    output logic                   FLATCH_B,
    output logic                   RS0,
    output logic                   RS1
);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic [BLW-1:0] words_q, words_d;
    logic [DW-1:0]  din_q, din_d;
    logic           load_q, load_d;
    logic           nop_done_q, nop_done_d;
    logic           turn_done;
    logic           drive_data;

    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_expire;

    bpi_phase_timer u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        words_d    = words_q;
        din_d      = din_q;
        load_d     = 1'b0;
        nop_done_d = 1'b0;
        turn_done  = 1'b0;
        drive_data = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = 8'd0;
        FCS_B      = 1'b1;
        FOE_B      = 1'b1;
        FWE_B      = 1'b1;
        FLATCH_B   = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (bus.EXECUTE) begin
                    addr_d  = bus.ADDR;
                    data_d  = bus.CMD_DATA_OUT;
                    op_d    = op_e'(bus.OP);
                    words_d = bus.BURST_LEN;
                    if (is_access(op_e'(bus.OP))) begin
                        state_d  = StLatch;
                        tmr_load = 1'b1;
                        tmr_val  = tmr_init(T_LATCH);
                    end else begin
                        nop_done_d = 1'b1;
                    end
                end
            end
            StLatch: begin
                FCS_B    = 1'b0;
                FLATCH_B = 1'b0;
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (op_q == OpWrite) begin
                        state_d = StWrite;
                        tmr_val = tmr_init(T_WR);
                    end else begin
                        state_d = StRdWait;
                        tmr_val = tmr_init(T_RD);
                    end
                end
            end
            StWrite: begin
                FCS_B      = 1'b0;
                FWE_B      = 1'b0;
                drive_data = 1'b1;
                if (tmr_expire) begin
                    state_d  = StTurn;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_init(T_TURN);
                end
            end
            StRdWait: begin
                FCS_B = 1'b0;
                FOE_B = 1'b0;
                if (tmr_expire) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                FCS_B    = 1'b0;
                FOE_B    = 1'b0;
                din_d    = CFG_DAT_I;
                load_d   = 1'b1;
                tmr_load = 1'b1;
                if (words_q != '0) begin
                    words_d = words_q - BLW'(1);
                    addr_d  = addr_q + AW'(1);
`ifdef BPI_PAGE_MODE_EN
                    // Same 8-word page: keep OE asserted and only wait the page access time.
                    if (addr_q[2:0] != 3'd7) begin
                        state_d = StRdWait;
                        tmr_val = tmr_init(T_PAGE);
                    end else begin
                        state_d = StLatch;
                        tmr_val = tmr_init(T_LATCH);
                    end
`else
                    state_d = StLatch;
                    tmr_val = tmr_init(T_LATCH);
`endif
                end else begin
                    state_d = StTurn;
                    tmr_val = tmr_init(T_TURN);
                end
            end
            StTurn: begin
                if (tmr_expire) begin
                    state_d   = StIdle;
                    turn_done = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            op_q       <= OpStandby;
            addr_q     <= '0;
            data_q     <= '0;
            words_q    <= '0;
            din_q      <= '0;
            load_q     <= 1'b0;
            nop_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            words_q    <= words_d;
            din_q      <= din_d;
            load_q     <= load_d;
            nop_done_q <= nop_done_d;
        end
    end

`ifndef BPI_PAGE_MODE_EN
    logic [7:0] unused_t_page;
    assign unused_t_page = 8'(T_PAGE);
`endif

    assign bus.BUSY      = (state_q != StIdle);
    assign bus.DONE      = nop_done_q | turn_done;
    assign bus.DATA_IN   = din_q;
    assign bus.LOAD_DATA = load_q;

    assign BPI_AD_O  = addr_q;
    // Pads carry the command word whenever the flash is selected or BPI owns them.
    assign CFG_DAT_O = (!FCS_B || BPI_ACTIVE) ? data_q : DUAL_DATA;
    assign CFG_DAT_T = drive_data ? {DW{1'b0}} : {DW{1'b1}};
    assign RS0       = 1'b0;
    assign RS1       = 1'b0;

endmodule

// File: tb/tb_bpi_ctrl_param.sv
// Directed self-checking bench for bpi_ctrl_param with a flash model returning addr[15:0].
module tb_bpi_ctrl_param;

    localparam int unsigned AW  = 23;
    localparam int unsigned DW  = 16;
    localparam int unsigned BLW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          BPI_ACTIVE = 1'b0;
    logic [DW-1:0] DUAL_DATA  = 16'hA5A5;
    logic [AW-1:0] BPI_AD_O;
    logic [DW-1:0] CFG_DAT_I, CFG_DAT_O, CFG_DAT_T;
    logic          FCS_B, FOE_B, FWE_B, FLATCH_B, RS0, RS1;

    bpi_ctrl_param_if #(.AW(AW), .DW(DW), .BLW(BLW)) bus ();

    bpi_ctrl_param dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .BPI_ACTIVE (BPI_ACTIVE),
        .DUAL_DATA  (DUAL_DATA),
        .BPI_AD_O   (BPI_AD_O),
        .CFG_DAT_I  (CFG_DAT_I),
        .CFG_DAT_O  (CFG_DAT_O),
        .CFG_DAT_T  (CFG_DAT_T),
        .FCS_B      (FCS_B),
        .FOE_B      (FOE_B),
        .FWE_B      (FWE_B),
        .FLATCH_B   (FLATCH_B),
        .RS0        (RS0),
        .RS1        (RS1)
    );

    always #5 CLK = ~CLK;

    assign CFG_DAT_I = BPI_AD_O[15:0];

    // Monitor: counts strobe/status activity on the falling edge.
    int            cyc = 0;
    int            busy_cnt = 0, done_cnt = 0, latch_cnt = 0, we_cnt = 0, overlap_cnt = 0;
    logic [AW-1:0] we_ad;
    logic [DW-1:0] we_dat_o, we_dat_t;
    logic [DW-1:0] rd_q[$];
    int            rd_cyc[$];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (bus.BUSY) busy_cnt <= busy_cnt + 1;
        if (bus.DONE) done_cnt <= done_cnt + 1;
        if (!FLATCH_B) latch_cnt <= latch_cnt + 1;
        if (!FWE_B && !FOE_B) overlap_cnt <= overlap_cnt + 1;
        if (!FWE_B) begin
            we_cnt   <= we_cnt + 1;
            we_ad    <= BPI_AD_O;
            we_dat_o <= CFG_DAT_O;
            we_dat_t <= CFG_DAT_T;
        end
        if (bus.LOAD_DATA) begin
            rd_q.push_back(bus.DATA_IN);
            rd_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic start(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BLW-1:0] blen);
        bus.OP           = op;
        bus.ADDR         = addr;
        bus.CMD_DATA_OUT = data;
        bus.BURST_LEN    = blen;
        bus.EXECUTE      = 1'b1;
        @(posedge CLK); #1;
        bus.EXECUTE      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base_done);
        int n = 0;
        while (!(done_cnt > base_done && !bus.BUSY) && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    int b_busy, b_done, b_latch, b_we, b_rd;

    task automatic snap();
        b_busy = busy_cnt; b_done = done_cnt; b_latch = latch_cnt;
        b_we = we_cnt; b_rd = rd_q.size();
    endtask

    initial begin
        bus.EXECUTE = 1'b0; bus.OP = 2'b00; bus.ADDR = '0;
        bus.CMD_DATA_OUT = '0; bus.BURST_LEN = '0;
        #12;
        check("rst_busy", 32'(bus.BUSY), 0);
        check("rst_done", 32'(bus.DONE), 0);
        check("rst_load", 32'(bus.LOAD_DATA), 0);
        check("rst_data_in", 32'(bus.DATA_IN), 0);
        check("rst_ad", 32'(BPI_AD_O), 0);
        check("rst_dat_t", 32'(CFG_DAT_T), 32'hFFFF);
        check("rst_strobes", {28'd0, FCS_B, FOE_B, FWE_B, FLATCH_B}, 32'hF);
        check("rst_rs", {30'd0, RS0, RS1}, 0);
        RST = 1'b0;
        tick(2);

        // Single write
        snap();
        start(2'b01, 23'h001234, 16'h00FF, '0);
        wait_done("wr_bound", b_done);
        tick(2);
        check("wr_latch_cycles", 32'(latch_cnt - b_latch), 2);
        check("wr_we_cycles", 32'(we_cnt - b_we), 4);
        check("wr_busy_cycles", 32'(busy_cnt - b_busy), 7);
        check("wr_done_count", 32'(done_cnt - b_done), 1);
        check("wr_ad", 32'(we_ad), 32'h001234);
        check("wr_dat_o", 32'(we_dat_o), 32'h00FF);
        check("wr_dat_t", 32'(we_dat_t), 0);

        // Pad mux while idle
        check("mux_dual", 32'(CFG_DAT_O), 32'hA5A5);
        BPI_ACTIVE = 1'b1; #1;
        check("mux_bpi", 32'(CFG_DAT_O), 32'h00FF);
        BPI_ACTIVE = 1'b0;

        // Burst read across the top of the address space
        snap();
        start(2'b10, 23'h7FFFFE, 16'h0000, 5'd3);
        wait_done("rd_bound", b_done);
        tick(2);
        check("rd_words", 32'(rd_q.size() - b_rd), 4);
        check("rd_w0", 32'(rd_q[b_rd]), 32'hFFFE);
        check("rd_w1", 32'(rd_q[b_rd+1]), 32'hFFFF);
        check("rd_w2", 32'(rd_q[b_rd+2]), 32'h0000);
        check("rd_w3", 32'(rd_q[b_rd+3]), 32'h0001);
        check("rd_done_count", 32'(done_cnt - b_done), 1);
        check("rd_we_cycles", 32'(we_cnt - b_we), 0);

        // Standby op
        snap();
        start(2'b11, 23'h000777, 16'h1111, '0);
        check("nop_done", 32'(bus.DONE), 1);
        check("nop_busy", 32'(bus.BUSY), 0);
        check("nop_strobes", {28'd0, FCS_B, FOE_B, FWE_B, FLATCH_B}, 32'hF);
        tick(1);
        check("nop_done_clear", 32'(bus.DONE), 0);
        check("nop_busy_later", 32'(bus.BUSY), 0);

        // EXECUTE while busy is dropped
        snap();
        start(2'b10, 23'h000100, 16'h0000, 5'd1);
        tick(4);
        start(2'b01, 23'h000200, 16'hBEEF, '0);
        wait_done("ign_bound", b_done);
        tick(4);
        check("ign_words", 32'(rd_q.size() - b_rd), 2);
        check("ign_w0", 32'(rd_q[b_rd]), 32'h0100);
        check("ign_w1", 32'(rd_q[b_rd+1]), 32'h0101);
        check("ign_done_count", 32'(done_cnt - b_done), 1);
        check("ign_no_write", 32'(we_cnt - b_we), 0);
        check("ign_idle", 32'(bus.BUSY), 0);

        // Reset in the middle of a write
        snap();
        start(2'b01, 23'h000042, 16'h1234, '0);
        tick(3);
        check("rstw_in_write", 32'(FWE_B), 0);
        #2 RST = 1'b1;
        #1;
        check("rstw_fwe", 32'(FWE_B), 1);
        check("rstw_fcs", 32'(FCS_B), 1);
        check("rstw_busy", 32'(bus.BUSY), 0);
        check("rstw_dat_t", 32'(CFG_DAT_T), 32'hFFFF);
        tick(1);
        RST = 1'b0;
        tick(3);
        check("rstw_no_done", 32'(done_cnt - b_done), 0);
        snap();
        start(2'b10, 23'h000055, 16'h0000, 5'd0);
        wait_done("rstw_rd_bound", b_done);
        tick(2);
        check("rstw_rd_words", 32'(rd_q.size() - b_rd), 1);
        check("rstw_rd_w0", 32'(rd_q[b_rd]), 32'h0055);
        check("rstw_rd_done", 32'(done_cnt - b_done), 1);

        // Four-word in-page burst
        snap();
        start(2'b10, 23'h000010, 16'h0000, 5'd3);
        wait_done("pg_bound", b_done);
        tick(2);
        check("pg_words", 32'(rd_q.size() - b_rd), 4);
        check("pg_w3", 32'(rd_q[b_rd+3]), 32'h0013);
`ifdef BPI_PAGE_MODE_EN
        check("pg_latch_cycles", 32'(latch_cnt - b_latch), 2);
        check("pg_spacing", 32'(rd_cyc[b_rd+1] - rd_cyc[b_rd]), 3);
        check("pg_spacing_last", 32'(rd_cyc[b_rd+3] - rd_cyc[b_rd+2]), 3);
`else
        check("pg_latch_cycles", 32'(latch_cnt - b_latch), 8);
        check("pg_spacing", 32'(rd_cyc[b_rd+1] - rd_cyc[b_rd]), 9);
        check("pg_spacing_last", 32'(rd_cyc[b_rd+3] - rd_cyc[b_rd+2]), 9);
`endif
        check("oe_we_overlap", 32'(overlap_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bpi_ctrl_param.md
Name: bpi_ctrl_param

Overview:
Parametrised BPI parallel-flash bus controller, successor to the fixed-width single-access BPI interface.
- Generalises address/data width and adds per-phase programmable wait states.
- Adds multi-word sequential burst reads, a completion strobe, and an explicit no-op acknowledge.
- Sits between the flash-programming command sequencer and the pad ring; the parent instantiates the pad buffers from the split in/out/oe signals.

Parameters:
AW, 23, flash address width
DW, 16, flash data width
BLW, 5, burst-length field width; max burst is 2^BLW words
T_LATCH, 2, cycles FLATCH_B low per address phase (1..255)
T_WR, 4, cycles FWE_B low per write (1..255)
T_RD, 6, cycles FOE_B low before first read sample (1..255)
T_TURN, 1, idle cycles with FCS_B high between accesses (1..255)
T_PAGE, 2, cycles per in-page word; used only with page-mode feature (1..255)

Ports:
CLK  in  1  system clock (40 MHz)
RST  in  1  asynchronous reset, active-high
ADDR  in  AW  start address, sampled on accepted EXECUTE
CMD_DATA_OUT  in  DW  command/data to write, sampled on accepted EXECUTE
OP  in  2  00 standby, 01 write, 10 read, 11 standby
BURST_LEN  in  BLW  read words minus 1; ignored for writes
EXECUTE  in  1  start request; single-cycle pulse or level
BUSY  out  1  operation in progress
DONE  out  1  one-cycle pulse at operation end
DATA_IN  out  DW  last word read
LOAD_DATA  out  1  one-cycle strobe: DATA_IN valid this cycle
BPI_ACTIVE  in  1  data pads are owned by BPI when high
DUAL_DATA  in  DW  pad data for non-BPI use
BPI_AD_O  out  AW  address pad drive
CFG_DAT_I  in  DW  data pad input
CFG_DAT_O  out  DW  data pad drive
CFG_DAT_T  out  DW  data pad tristate (1 = high-Z)
FCS_B, FOE_B, FWE_B, FLATCH_B  out  1 each  active-low flash strobes
RS0, RS1  out  1 each  driven 0, tristated by parent

Behaviour:
- Reset values: all strobes high, BUSY=0, DONE=0, LOAD_DATA=0, DATA_IN=0, BPI_AD_O=0, CFG_DAT_T all 1, state IDLE. Reset mid-operation aborts immediately with no completion pulse.
- States: IDLE, LATCH, WRITE, RD_WAIT, SAMPLE, TURN.
- IDLE: EXECUTE with BUSY=0 is accepted. The block registers ADDR, data, OP and BURST_LEN, and sets BUSY next cycle.
  - OP 00/11: DONE pulses the next cycle; BUSY stays 0; no bus activity.
- LATCH: FCS_B=0 and FLATCH_B=0 for T_LATCH cycles. Next state is WRITE (op 01) or RD_WAIT (op 10).
- WRITE: FCS_B=0 and FWE_B=0 for T_WR cycles; CFG_DAT_T=0. Then TURN.
- RD_WAIT: FCS_B=0, FOE_B=0, CFG_DAT_T all 1 for T_RD cycles. Then SAMPLE.
- SAMPLE (1 cycle): DATA_IN<=CFG_DAT_I and LOAD_DATA=1. The word counter decrements.
  - Remaining>0: address+1 (modulo 2^AW, wraps to 0), then LATCH.
  - Otherwise: TURN.
- TURN: all strobes high for T_TURN cycles. DONE pulses in the last TURN cycle; BUSY drops the following cycle.
- EXECUTE while BUSY=1 is ignored and is not queued.
- Mux rule: CFG_DAT_O = data register when FCS active or BPI_ACTIVE, else DUAL_DATA.
- FOE_B and FWE_B are never low in the same cycle.
- A T_x value of 1 means a single cycle.
- Timing counter is 8 bits and loads with T_x-1.

Optional Feature:
BPI_PAGE_MODE_EN
- Defined: within a burst, after the first SAMPLE, if the next address stays in the same 8-word page (addr[2:0] != 7 before increment), skip LATCH. FOE_B and FCS_B stay low, BPI_AD_O updates, and the next sample comes after T_PAGE cycles. A page crossing relatches normally.
- Undefined: every word is relatched; T_PAGE is unused.

Decomposition:
- Package bpi_pkg: OP encodings, state enum, default timing constants.
- One sub-module, bpi_phase_timer: 8-bit loadable down-counter with load/expire, instantiated once and shared across phases.

Test Plan:
- Write, ADDR=0x00_1234, data=0x00FF, OP=01, defaults:
  - FLATCH_B low 2 cycles, FWE_B low 4 cycles, BPI_AD_O=0x001234, CFG_DAT_O=0x00FF, CFG_DAT_T=0 during WRITE.
  - DONE once; BUSY high 7 cycles + accept cycle.
- Read burst, ADDR=0x7FFFFE, BURST_LEN=3, flash model returns addr[15:0]:
  - Four LOAD_DATA pulses with DATA_IN 0xFFFE, 0xFFFF, 0x0000, 0x0001 (address wraps).
  - One DONE.
- OP=11 with EXECUTE: DONE the next cycle; BUSY and all strobes unchanged.
- EXECUTE pulsed mid-read: ignored; only the original burst completes; exactly one DONE.
- Assert RST during WRITE: FWE_B and FCS_B high asynchronously, BUSY=0, no DONE; a subsequent read works.
- BPI_ACTIVE=0, idle, DUAL_DATA=0xA5A5: CFG_DAT_O=0xA5A5.
  - With BPI_PAGE_MODE_EN, burst 4 from 0x10: one FLATCH pulse, samples spaced T_PAGE+1 cycles.
